port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-port frame counter.
REQ-002 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_h_dout  in  4*113  per-port header {valid, dst[47:0], src[47:0], type[15:0]}; port p at [113p+112:113p].
REQ-005 SHALL have port rx_h_empty  in  4  per-port header FIFO empty.
REQ-006 SHALL have port rx_h_rden  out  4  per-port header pop.
REQ-007 SHALL have port rx_b_dout  in  4*8  per-port payload byte; port p at [8p+7:8p].
REQ-008 SHALL have port rx_b_del  in  4  per-port payload delimiter (last byte of frame).
REQ-009 SHALL have port rx_b_empty  in  4  per-port payload FIFO empty.
REQ-010 SHALL have port rx_b_rden  out  4  per-port payload pop.
REQ-011 SHALL have port h_fifo_din  out  115  shared header {valid, port[1:0], dst, src, type}.
REQ-012 SHALL have port h_fifo_wren  out  1  shared header write.
REQ-013 SHALL have port h_fifo_afull  in  1  shared header FIFO almost full.
REQ-014 SHALL have port b_fifo_din  out  8  shared payload byte.
REQ-015 SHALL have port b_fifo_del  out  1  shared payload delimiter.
REQ-016 SHALL have port b_fifo_wren  out  1  shared payload write.
REQ-017 SHALL have port b_fifo_afull  in  1  shared payload FIFO almost full.
REQ-018 SHALL have port frame_cnt  out  4*CNT_W  per-port forwarded-frame counters.

Function
REQ-019 SHALL treat all rx FIFOs as first-word-fall-through: dout valid whenever empty=0, rden pops.
REQ-020 SHALL implement states IDLE, HDR, BODY, DONE held in a registered state and registered grant g[1:0].
REQ-021 SHALL, in IDLE, when any rx_h_empty bit is 0, grant the first non-empty port searching from last_grant+1 modulo 4, then enter HDR; stay in IDLE otherwise.
REQ-022 SHALL, in HDR with h_fifo_afull=0, assert h_fifo_wren and rx_h_rden[g] for exactly one cycle with h_fifo_din = {hdr[112], g, hdr[111:0]}, then enter BODY; stall in HDR while h_fifo_afull=1.
REQ-023 SHALL, in BODY, each cycle rx_b_empty[g]=0 and b_fifo_afull=0, assert rx_b_rden[g] and b_fifo_wren together, with b_fifo_din=rx_b_dout[g], b_fifo_del=rx_b_del[g].
REQ-024 SHALL stall in BODY without writing while rx_b_empty[g]=1 or b_fifo_afull=1, and resume with no byte lost or duplicated.
REQ-025 SHALL, on the cycle the delimiter byte is transferred, enter DONE; DONE SHALL update last_grant=g, increment frame_cnt[g] (wrap at 2^CNT_W), return to IDLE.
REQ-026 SHALL drive rden/wren combinationally from registered state and current flags (zero-latency transfer); at most one rx_*_rden bit SHALL be high per cycle.
REQ-027 SHALL never switch grant mid-frame; payload bytes of different ports SHALL never interleave in the shared payload FIFO.
REQ-028 SHALL forward frames with valid=0 unchanged (discard is a downstream decision).
REQ-029 SHALL give minimum frame overhead of 3 cycles (IDLE, HDR, DONE) plus one cycle per payload byte.

Reset
REQ-030 SHALL, with arst_n=0, asynchronously force state=IDLE, g=0, last_grant=3 (first search starts at port 0), frame_cnt=0, all rden/wren=0.
REQ-031 SHALL abandon any in-flight frame on reset assertion; no recovery of partial frames.

Configuration
REQ-032 SHALL compile frame counters only when macro PORT_ARBITER_STATS_EN is defined; otherwise frame_cnt SHALL be tied to 0 and no counter flops exist.

Structure
REQ-033 SHALL take NUM_PORTS=4, RX_HDR_W=113, SW_HDR_W=115 and the state encoding from shared package arb_pkg.
REQ-034 SHALL place the 4-way round-robin pick in sub-module rr_pick (inputs req[3:0], last[1:0]; outputs gnt[1:0], any).

Verification
REQ-035 SHALL cover: port 2 only, header type 0x0800, 4-byte payload -> h_fifo_din[113:112]=2, 4 payload writes, b_fifo_del=1 on byte 4, frame_cnt[2]=1.
REQ-036 SHALL cover: all four ports ready simultaneously after reset -> grant order 0,1,2,3, then 0 again when refilled.
REQ-037 SHALL cover: b_fifo_afull=1 for 5 cycles mid-frame of 10 bytes -> no wren during stall, all 10 bytes in order afterwards.
REQ-038 SHALL cover: rx_b_empty[g] toggling every other cycle while port 1 also has a pending header -> no interleaving, port 1 granted only after delimiter.
REQ-039 SHALL cover: arst_n pulsed low during BODY -> all outputs 0 immediately, state IDLE, counters 0.
REQ-040 SHALL cover: 2^CNT_W+1 frames on port 0 with PORT_ARBITER_STATS_EN -> frame_cnt[0]=1; without macro -> frame_cnt=0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared port count, header widths and arbiter state encoding.
package arb_pkg;
  localparam int NUM_PORTS = 4;
  localparam int RX_HDR_W = 113;
  localparam int SW_HDR_W = 115;
  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: 4-way round-robin pick, first requester after last (mod 4).
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last,
  output logic [1:0]           gnt,
  output logic                 any
);
  logic [1:0] c;
  always_comb begin
    gnt = '0;
    c = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      c = last + 2'(k);
      if (req[c]) gnt = c;
    end
    any = |req;
  end
endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: frame-granular 4-port arbiter; PORT_ARBITER_STATS_EN adds per-port frame counters.
module port_arbiter
  import arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [NUM_PORTS*RX_HDR_W-1:0] rx_h_dout,
  input  logic [NUM_PORTS-1:0]          rx_h_empty,
  output logic [NUM_PORTS-1:0]          rx_h_rden,
  input  logic [NUM_PORTS*8-1:0]        rx_b_dout,
  input  logic [NUM_PORTS-1:0]          rx_b_del,
  input  logic [NUM_PORTS-1:0]          rx_b_empty,
  output logic [NUM_PORTS-1:0]          rx_b_rden,
  output logic [SW_HDR_W-1:0]           h_fifo_din,
  output logic                          h_fifo_wren,
  input  logic                          h_fifo_afull,
  output logic [7:0]                    b_fifo_din,
  output logic                          b_fifo_del,
  output logic                          b_fifo_wren,
  input  logic                          b_fifo_afull,
  output logic [NUM_PORTS*CNT_W-1:0]    frame_cnt
);
  state_t state_q, state_d;
  logic [1:0] g_q, g_d, last_q, last_d, pick;
  logic any, hwr, xfer, del;
  logic [RX_HDR_W-1:0] hdr;
  logic [7:0] bdat;

  rr_pick u_pick (
    .req  (~rx_h_empty),
    .last (last_q),
    .gnt  (pick),
    .any  (any)
  );

  assign hdr  = rx_h_dout[32'(g_q)*RX_HDR_W +: RX_HDR_W];
  assign bdat = rx_b_dout[32'(g_q)*8 +: 8];
  assign del  = rx_b_del[g_q];
  assign hwr  = state_q == HDR && !h_fifo_afull;
  assign xfer = state_q == BODY && !rx_b_empty[g_q] && !b_fifo_afull;

  always_comb begin
    state_d = state_q;
    g_d = g_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (any) begin
        g_d = pick;
        state_d = HDR;
      end
      HDR:  if (hwr) state_d = BODY;
      BODY: if (xfer && del) state_d = DONE;
      DONE: begin
        last_d = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      g_q <= '0;
      last_q <= 2'd3;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      last_q <= last_d;
    end
  end

  // Data outputs are gated so idle and reset cycles present all-zero buses.
  assign h_fifo_wren = hwr;
  assign rx_h_rden   = {NUM_PORTS{hwr}} & (NUM_PORTS'(1) << g_q);
  assign h_fifo_din  = hwr ? {hdr[RX_HDR_W-1], g_q, hdr[RX_HDR_W-2:0]} : '0;
  assign b_fifo_wren = xfer;
  assign rx_b_rden   = {NUM_PORTS{xfer}} & (NUM_PORTS'(1) << g_q);
  assign b_fifo_din  = xfer ? bdat : '0;
  assign b_fifo_del  = xfer & del;

`ifdef PORT_ARBITER_STATS_EN
  logic [NUM_PORTS*CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DONE) cnt_d[32'(g_q)*CNT_W +: CNT_W] = cnt_q[32'(g_q)*CNT_W +: CNT_W] + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign frame_cnt = cnt_q;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: directed and random frames checked against a frame-level round-robin scoreboard.
module tb_port_arbiter;
  localparam int CW = 3;
`ifdef PORT_ARBITER_STATS_EN
  localparam bit STATS = 1;
`else
  localparam bit STATS = 0;
`endif

  logic clk = 0, arst_n;
  logic [451:0] rx_h_dout;
  logic [3:0] rx_h_empty, rx_h_rden, rx_b_del, rx_b_empty, rx_b_rden;
  logic [31:0] rx_b_dout;
  logic [114:0] h_fifo_din;
  logic h_fifo_wren, h_fifo_afull, b_fifo_del, b_fifo_wren, b_fifo_afull;
  logic [7:0] b_fifo_din;
  logic [4*CW-1:0] frame_cnt;

  port_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n),
    .rx_h_dout(rx_h_dout), .rx_h_empty(rx_h_empty), .rx_h_rden(rx_h_rden),
    .rx_b_dout(rx_b_dout), .rx_b_del(rx_b_del), .rx_b_empty(rx_b_empty), .rx_b_rden(rx_b_rden),
    .h_fifo_din(h_fifo_din), .h_fifo_wren(h_fifo_wren), .h_fifo_afull(h_fifo_afull),
    .b_fifo_din(b_fifo_din), .b_fifo_del(b_fifo_del), .b_fifo_wren(b_fifo_wren), .b_fifo_afull(b_fifo_afull),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [112:0] hq [4][$];
  logic [8:0] bq [4][$];
  logic [114:0] exp_h [$];
  logic [10:0] exp_b [$];
  int gorder [$];
  int passes = 0, checks = 0, mlast = 3, nb = 0, pb = 0, ph = 0, phide = 0, force_baf = 0;
  int mcnt [4] = '{default: 0};
  logic [3:0] hide = '0;
  bit toggle = 0, tphase = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_rx();
    for (int p = 0; p < 4; p++) begin
      rx_h_empty[p] = hq[p].size() == 0;
      rx_h_dout[p*113 +: 113] = hq[p].size() > 0 ? hq[p][0] : '0;
      rx_b_empty[p] = bq[p].size() == 0 || hide[p];
      rx_b_dout[p*8 +: 8] = bq[p].size() > 0 ? bq[p][0][7:0] : '0;
      rx_b_del[p] = bq[p].size() > 0 ? bq[p][0][8] : 1'b0;
    end
  endtask

  task automatic add_frame(input int p, input int len, input bit v, input int typ);
    logic [127:0] r;
    logic [112:0] h;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    h = {v, r[111:0]};
    if (typ >= 0) h[15:0] = 16'(typ);
    hq[p].push_back(h);
    for (int i = 0; i < len; i++) bq[p].push_back({1'(i == len - 1), 8'($urandom_range(0, 255))});
  endtask

  // Whole-frame round robin over the frames currently queued at the rx ports.
  task automatic build_expect();
    int hi [4] = '{default: 0};
    int bi [4] = '{default: 0};
    int p;
    logic [8:0] b;
    forever begin
      p = -1;
      for (int k = 1; k <= 4; k++)
        if (p < 0 && hi[(mlast + k) % 4] < hq[(mlast + k) % 4].size()) p = (mlast + k) % 4;
      if (p < 0) break;
      exp_h.push_back({hq[p][hi[p]][112], 2'(p), hq[p][hi[p]][111:0]});
      hi[p]++;
      do begin
        b = bq[p][bi[p]];
        exp_b.push_back({2'(p), b});
        bi[p]++;
      end while (!b[8]);
      mcnt[p] = (mcnt[p] + 1) % (1 << CW);
      mlast = p;
    end
  endtask

  task automatic cycle();
    logic [3:0] rh, rb;
    logic [114:0] eh;
    logic [10:0] eb;
    @(negedge clk);
    b_fifo_afull = force_baf > 0 || $urandom_range(0, 99) < pb;
    if (force_baf > 0) force_baf--;
    h_fifo_afull = $urandom_range(0, 99) < ph;
    tphase = ~tphase;
    for (int p = 0; p < 4; p++) hide[p] = toggle ? tphase : $urandom_range(0, 99) < phide;
    drive_rx();
    #1;
    chk("rden_legal", {$onehot0(rx_h_rden), $onehot0(rx_b_rden), (rx_h_rden & rx_h_empty) == 0, (rx_b_rden & rx_b_empty) == 0}, 4'hf);
    chk("rden_wren", {|rx_h_rden, |rx_b_rden}, {h_fifo_wren, b_fifo_wren});
    chk("afull_hold", {h_fifo_afull & h_fifo_wren, b_fifo_afull & b_fifo_wren}, 2'b00);
`ifndef PORT_ARBITER_STATS_EN
    chk("cnt_tied", frame_cnt, 0);
`endif
    if (h_fifo_wren) begin
      chk("h_pending", exp_h.size() > 0, 1);
      if (exp_h.size() > 0) begin
        eh = exp_h.pop_front();
        chk("h_din", h_fifo_din, eh);
        chk("h_rden", rx_h_rden, 4'b1 << eh[113:112]);
      end
      gorder.push_back(int'(h_fifo_din[113:112]));
    end
    if (b_fifo_wren) begin
      chk("b_pending", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        eb = exp_b.pop_front();
        chk("b_data", {b_fifo_del, b_fifo_din}, eb[8:0]);
        chk("b_rden", rx_b_rden, 4'b1 << eb[10:9]);
      end
      nb++;
    end
    rh = rx_h_rden;
    rb = rx_b_rden;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (rh[p] && hq[p].size() > 0) void'(hq[p].pop_front());
      if (rb[p] && bq[p].size() > 0) void'(bq[p].pop_front());
    end
    drive_rx();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_h.size() > 0 || exp_b.size() > 0) && n < 3000) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk({tag, "_drained"}, exp_h.size() + exp_b.size(), 0);
    chk({tag, "_rx_empty"}, hq[0].size() + hq[1].size() + hq[2].size() + hq[3].size(), 0);
    for (int p = 0; p < 4; p++) chk({tag, "_frame_cnt"}, frame_cnt[p*CW +: CW], STATS ? mcnt[p] : 0);
  endtask

  task automatic run_until_bytes(input int k);
    int n = 0;
    while (nb < k && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_body", nb >= k, 1);
  endtask

  // Asserts reset between edges and checks that the outputs drop without a clock.
  task automatic do_reset();
    #2 arst_n = 0;
    #1;
    chk("rst_ctl", {h_fifo_wren, b_fifo_wren, b_fifo_del, rx_h_rden, rx_b_rden}, 0);
    chk("rst_hdin", h_fifo_din, 0);
    chk("rst_bdin", b_fifo_din, 0);
    chk("rst_cnt", frame_cnt, 0);
    for (int p = 0; p < 4; p++) begin
      hq[p].delete();
      bq[p].delete();
    end
    exp_h.delete();
    exp_b.delete();
    gorder.delete();
    mlast = 3;
    mcnt = '{default: 0};
    nb = 0;
    hide = '0;
    drive_rx();
    @(negedge clk);
    arst_n = 1;
  endtask

  initial begin
    arst_n = 0;
    h_fifo_afull = 0;
    b_fifo_afull = 0;
    drive_rx();
    do_reset();
    // port 2 only, IPv4 type, 4 bytes
    add_frame(2, 4, 1, 16'h0800);
    build_expect();
    drain("p2");
    chk("p2_bytes", nb, 4);
    chk("p2_port", gorder.size() > 0 ? gorder[0] : -1, 2);
    chk("p2_cnt", frame_cnt[2*CW +: CW], STATS ? 1 : 0);
    // all four ports ready after reset, then refilled
    do_reset();
    for (int p = 0; p < 4; p++) add_frame(p, 2 + p, 1, -1);
    build_expect();
    drain("rr1");
    for (int p = 0; p < 4; p++) add_frame(p, 3, p[0], -1);
    build_expect();
    drain("rr2");
    chk("rr_count", gorder.size(), 8);
    for (int i = 0; i < 5; i++) chk("rr_order", gorder.size() > i ? gorder[i] : -1, i % 4);
    // payload back-pressure for 5 cycles inside a 10-byte frame
    nb = 0;
    add_frame(1, 10, 1, -1);
    build_expect();
    run_until_bytes(3);
    force_baf = 5;
    drain("stall");
    chk("stall_bytes", nb, 10);
    // starved payload on port 0 while port 1 waits with a header
    do_reset();
    gorder.delete();
    add_frame(0, 8, 1, -1);
    add_frame(1, 3, 0, -1);
    toggle = 1;
    build_expect();
    drain("toggle");
    toggle = 0;
    chk("toggle_order", gorder.size() == 2 ? {gorder[0], gorder[1]} : 64'hffff, {32'd0, 32'd1});
    // reset in the middle of a payload
    add_frame(3, 12, 1, -1);
    build_expect();
    run_until_bytes(3);
    do_reset();
    add_frame(3, 2, 1, -1);
    build_expect();
    drain("post_rst");
    // counter wrap: 2^CW + 1 frames on port 0
    do_reset();
    for (int i = 0; i < (1 << CW) + 1; i++) add_frame(0, 1 + i % 3, 1, -1);
    build_expect();
    drain("wrap");
    chk("wrap_cnt0", frame_cnt[CW-1:0], STATS ? 1 : 0);
    // random traffic under random back-pressure and starvation
    pb = 20;
    ph = 25;
    phide = 25;
    for (int ph_i = 0; ph_i < 15; ph_i++) begin
      for (int p = 0; p < 4; p++)
        repeat ($urandom_range(0, 2)) add_frame(p, $urandom_range(1, 8), 1'($urandom_range(0, 1)), -1);
      build_expect();
      drain("rand");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
